// File: rtl/reg_bank_pkg.sv
// Shared definitions for the datapath register bank and the control FSM that drives it.
// Holds the write-port operation encodings.
package reg_bank_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_LOAD = 2'b00;
    localparam op_t OP_INC  = 2'b01;
    localparam op_t OP_DEC  = 2'b10;
    localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational next-value unit for one register: load, increment, decrement or clear.
// Also flags INC/DEC wrap-around.
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_wdata,
    input  op_t              i_op,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_wrapped
);

    always_comb begin
        o_nxt     = i_cur;
        o_wrapped = 1'b0;
        case (i_op)
            OP_LOAD: o_nxt = i_wdata;
            OP_INC: begin
                o_nxt     = i_cur + WIDTH'(1);
                o_wrapped = &i_cur;
            end
            OP_DEC: begin
                o_nxt     = i_cur - WIDTH'(1);
                o_wrapped = ~|i_cur;
            end
            OP_CLR:  o_nxt = '0;
            default: o_nxt = i_cur;
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank with one op-capable write port and two latched read ports.
// Read ports see this edge's write (bypass); every output is a flop.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld,
    input  op_t              i_op,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_t_a,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_out_a,
    output logic             o_zero_a,
    input  logic             i_t_b,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_out_b,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic             r_zero_a;
    logic             r_wrap;

    logic [WIDTH-1:0] w_cur;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic             w_waddr_ok;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_alu_nxt;
    logic             w_alu_wrapped;
    logic [WIDTH-1:0] w_nxt_a;
    logic [WIDTH-1:0] w_nxt_b;

    // Decoding by loop means out-of-range addresses (DEPTH not a power of two) match nothing
    // and naturally read as zero.
    always_comb begin
        w_cur      = '0;
        w_rd_a     = '0;
        w_rd_b     = '0;
        w_waddr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_waddr == AW'(i)) begin
                w_cur      = r_regs[i];
                w_waddr_ok = 1'b1;
            end
            if (i_raddr_a == AW'(i)) begin
                w_rd_a = r_regs[i];
            end
            if (i_raddr_b == AW'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
    end

    assign w_wr_en = i_ld & w_waddr_ok;

    reg_bank_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .i_cur    (w_cur),
        .i_wdata  (i_wdata),
        .i_op     (i_op),
        .o_nxt    (w_alu_nxt),
        .o_wrapped(w_alu_wrapped)
    );

    // A hit implies the read address is in range, since w_wr_en requires a valid waddr.
    always_comb begin
        w_nxt_a = w_rd_a;
        w_nxt_b = w_rd_b;
        if (w_wr_en && (i_waddr == i_raddr_a)) begin
            w_nxt_a = w_alu_nxt;
        end
        if (w_wr_en && (i_waddr == i_raddr_b)) begin
            w_nxt_b = w_alu_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en && (i_waddr == AW'(i))) begin
                    r_regs[i] <= w_alu_nxt;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_a  <= '0;
            r_out_b  <= '0;
            r_zero_a <= 1'b1;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= w_wr_en & w_alu_wrapped;
            if (i_t_a) begin
                r_out_a  <= w_nxt_a;
                r_zero_a <= (w_nxt_a == '0);
            end
            if (i_t_b) begin
                r_out_b <= w_nxt_b;
            end
        end
    end

    assign o_out_a  = r_out_a;
    assign o_out_b  = r_out_b;
    assign o_zero_a = r_zero_a;
    assign o_wrap   = r_wrap;

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: a DEPTH=8 instance for the main scenarios and a
// DEPTH=6 instance for out-of-range addressing.
module tb_reg_bank;

    logic        clk;
    logic        rst;
    logic        ld;
    logic [1:0]  op;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        t_a;
    logic [2:0]  raddr_a;
    logic [15:0] out_a;
    logic        zero_a;
    logic        t_b;
    logic [2:0]  raddr_b;
    logic [15:0] out_b;
    logic        wrap;

    logic        s_rst;
    logic        s_ld;
    logic [1:0]  s_op;
    logic [2:0]  s_waddr;
    logic [15:0] s_wdata;
    logic        s_t_a;
    logic [2:0]  s_raddr_a;
    logic [15:0] s_out_a;
    logic        s_zero_a;
    logic        s_t_b;
    logic [2:0]  s_raddr_b;
    logic [15:0] s_out_b;
    logic        s_wrap;

    int checks;
    int errors;

    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] INC  = 2'b01;
    localparam logic [1:0] DEC  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    reg_bank #(
        .WIDTH(16),
        .DEPTH(8)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ld     (ld),
        .i_op     (op),
        .i_waddr  (waddr),
        .i_wdata  (wdata),
        .i_t_a    (t_a),
        .i_raddr_a(raddr_a),
        .o_out_a  (out_a),
        .o_zero_a (zero_a),
        .i_t_b    (t_b),
        .i_raddr_b(raddr_b),
        .o_out_b  (out_b),
        .o_wrap   (wrap)
    );

    reg_bank #(
        .WIDTH(16),
        .DEPTH(6)
    ) dut6 (
        .i_clk    (clk),
        .i_rst    (s_rst),
        .i_ld     (s_ld),
        .i_op     (s_op),
        .i_waddr  (s_waddr),
        .i_wdata  (s_wdata),
        .i_t_a    (s_t_a),
        .i_raddr_a(s_raddr_a),
        .o_out_a  (s_out_a),
        .o_zero_a (s_zero_a),
        .i_t_b    (s_t_b),
        .i_raddr_b(s_raddr_b),
        .o_out_b  (s_out_b),
        .o_wrap   (s_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; ld = 1'b0; op = LOAD; waddr = '0; wdata = '0;
        t_a = 1'b0; raddr_a = '0; t_b = 1'b0; raddr_b = '0;
        s_rst = 1'b0; s_ld = 1'b0; s_op = LOAD; s_waddr = '0; s_wdata = '0;
        s_t_a = 1'b0; s_raddr_a = '0; s_t_b = 1'b0; s_raddr_b = '0;
    endtask

    task automatic write(input logic [2:0] a, input logic [1:0] o, input logic [15:0] d);
        ld = 1'b1; waddr = a; op = o; wdata = d;
    endtask

    task automatic test_reset();
        idle(); write(3'd3, LOAD, 16'h5555); tick();
        idle(); write(3'd4, LOAD, 16'hFFFF); tick();
        // Reset with a wrapping INC and both transfers pending: reset must win.
        idle(); rst = 1'b1; write(3'd4, INC, 16'h0);
        t_a = 1'b1; raddr_a = 3'd3; t_b = 1'b1; raddr_b = 3'd3;
        tick();
        checks++; if (out_a !== 16'h0) begin errors++; $display("FAIL reset_out_a got %h want 0000", out_a); end
        checks++; if (out_b !== 16'h0) begin errors++; $display("FAIL reset_out_b got %h want 0000", out_b); end
        checks++; if (zero_a !== 1'b1) begin errors++; $display("FAIL reset_zero_a got %b want 1", zero_a); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        for (int a = 0; a < 8; a++) begin
            idle(); t_a = 1'b1; raddr_a = 3'(a); t_b = 1'b1; raddr_b = 3'(7 - a);
            tick();
            checks++;
            if (out_a !== 16'h0) begin errors++; $display("FAIL reset_reg_a r%0d got %h want 0000", a, out_a); end
            checks++;
            if (out_b !== 16'h0) begin errors++; $display("FAIL reset_reg_b r%0d got %h want 0000", 7 - a, out_b); end
        end
    endtask

    task automatic test_load_transfer();
        idle(); write(3'd2, LOAD, 16'h1234); tick();
        idle(); t_a = 1'b1; raddr_a = 3'd2; tick();
        checks++; if (out_a !== 16'h1234) begin errors++; $display("FAIL load_out_a got %h want 1234", out_a); end
        checks++; if (zero_a !== 1'b0) begin errors++; $display("FAIL load_zero_a got %b want 0", zero_a); end
        idle(); write(3'd2, LOAD, 16'hFFFF); tick();
        checks++; if (out_a !== 16'h1234) begin errors++; $display("FAIL hold_out_a got %h want 1234", out_a); end
        idle(); t_b = 1'b1; raddr_b = 3'd2; tick();
        checks++; if (out_b !== 16'hFFFF) begin errors++; $display("FAIL reload_out_b got %h want ffff", out_b); end
        checks++; if (out_a !== 16'h1234) begin errors++; $display("FAIL hold2_out_a got %h want 1234", out_a); end
        idle(); write(3'd2, CLR, 16'h0); t_a = 1'b1; raddr_a = 3'd2; tick();
        checks++; if (out_a !== 16'h0) begin errors++; $display("FAIL clr_out_a got %h want 0000", out_a); end
        checks++; if (zero_a !== 1'b1) begin errors++; $display("FAIL clr_zero_a got %b want 1", zero_a); end
    endtask

    task automatic test_bypass();
        idle(); write(3'd5, LOAD, 16'hBEEF);
        t_a = 1'b1; raddr_a = 3'd5; t_b = 1'b1; raddr_b = 3'd5;
        tick();
        checks++; if (out_a !== 16'hBEEF) begin errors++; $display("FAIL bypass_out_a got %h want beef", out_a); end
        checks++; if (out_b !== 16'hBEEF) begin errors++; $display("FAIL bypass_out_b got %h want beef", out_b); end
        checks++; if (zero_a !== 1'b0) begin errors++; $display("FAIL bypass_zero_a got %b want 0", zero_a); end
        idle(); write(3'd5, INC, 16'h0);
        t_a = 1'b1; raddr_a = 3'd5; t_b = 1'b1; raddr_b = 3'd4;
        tick();
        checks++; if (out_a !== 16'hBEF0) begin errors++; $display("FAIL bypass_inc_a got %h want bef0", out_a); end
        checks++; if (out_b !== 16'h0) begin errors++; $display("FAIL bypass_other_b got %h want 0000", out_b); end
    endtask

    task automatic test_wrap();
        idle(); write(3'd1, LOAD, 16'hFFFE); tick();
        idle(); write(3'd1, INC, 16'h0); t_a = 1'b1; raddr_a = 3'd1; tick();
        checks++; if (out_a !== 16'hFFFF) begin errors++; $display("FAIL inc1_out_a got %h want ffff", out_a); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL inc1_wrap got %b want 0", wrap); end
        idle(); write(3'd1, INC, 16'h0); t_a = 1'b1; raddr_a = 3'd1; tick();
        checks++; if (out_a !== 16'h0) begin errors++; $display("FAIL inc2_out_a got %h want 0000", out_a); end
        checks++; if (zero_a !== 1'b1) begin errors++; $display("FAIL inc2_zero_a got %b want 1", zero_a); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL inc2_wrap got %b want 1", wrap); end
        idle(); tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL inc_wrap_clear got %b want 0", wrap); end
        idle(); write(3'd1, DEC, 16'h0); t_a = 1'b1; raddr_a = 3'd1; tick();
        checks++; if (out_a !== 16'hFFFF) begin errors++; $display("FAIL dec_out_a got %h want ffff", out_a); end
        checks++; if (zero_a !== 1'b0) begin errors++; $display("FAIL dec_zero_a got %b want 0", zero_a); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL dec_wrap got %b want 1", wrap); end
        idle(); write(3'd1, DEC, 16'h0); tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL dec_nowrap got %b want 0", wrap); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 5; k++) begin
            idle(); write(3'd7, INC, 16'h0); t_b = 1'b1; raddr_b = 3'd7;
            tick();
            checks++;
            if (out_b !== 16'(k)) begin errors++; $display("FAIL count_out_b step %0d got %h want %h", k, out_b, 16'(k)); end
            checks++;
            if (wrap !== 1'b0) begin errors++; $display("FAIL count_wrap step %0d got %b want 0", k, wrap); end
        end
        idle(); t_a = 1'b1; raddr_a = 3'd7; tick();
        checks++; if (out_a !== 16'h5) begin errors++; $display("FAIL count_final_a got %h want 0005", out_a); end
    endtask

    task automatic test_depth6();
        idle(); s_rst = 1'b1; tick();
        idle(); s_ld = 1'b1; s_waddr = 3'd5; s_op = LOAD; s_wdata = 16'h1357; tick();
        idle(); s_ld = 1'b1; s_waddr = 3'd7; s_op = LOAD; s_wdata = 16'hAAAA; tick();
        idle(); s_ld = 1'b1; s_waddr = 3'd6; s_op = LOAD; s_wdata = 16'hAAAA; tick();
        // An out-of-range DEC would underflow if the missing register read as zero.
        idle(); s_ld = 1'b1; s_waddr = 3'd7; s_op = DEC; tick();
        checks++; if (s_wrap !== 1'b0) begin errors++; $display("FAIL d6_oob_dec_wrap got %b want 0", s_wrap); end
        for (int a = 0; a < 6; a++) begin
            idle(); s_t_a = 1'b1; s_raddr_a = 3'(a); tick();
            checks++;
            if (s_out_a !== ((a == 5) ? 16'h1357 : 16'h0)) begin
                errors++;
                $display("FAIL d6_reg r%0d got %h want %h", a, s_out_a, (a == 5) ? 16'h1357 : 16'h0);
            end
        end
        idle(); s_t_b = 1'b1; s_raddr_b = 3'd5; tick();
        idle(); s_t_a = 1'b1; s_raddr_a = 3'd6; s_t_b = 1'b1; s_raddr_b = 3'd7; tick();
        checks++; if (s_out_a !== 16'h0) begin errors++; $display("FAIL d6_oob_out_a got %h want 0000", s_out_a); end
        checks++; if (s_zero_a !== 1'b1) begin errors++; $display("FAIL d6_oob_zero_a got %b want 1", s_zero_a); end
        checks++; if (s_out_b !== 16'h0) begin errors++; $display("FAIL d6_oob_out_b got %h want 0000", s_out_b); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        s_rst = 1'b1;
        tick();
        tick();
        test_reset();
        test_load_transfer();
        test_bypass();
        test_wrap();
        test_back_to_back();
        test_depth6();
        idle();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
